// File: rtl/fsfifo_drain.sv
// -----------------------------------------------------------------------------
// fsfifo_drain
//
// Drains an upstream synchronous FIFO (1-cycle read latency) into a
// valid/ready output stream through a 3-entry in-order skid buffer.
// Reads are issued only when the buffer is certain to have room for the
// returning word. As a result, the read strobe never depends on m_ready_i,
// and the buffer can never overflow.
//
// Optional feature (macro FSFIFO_DRAIN_LAST_EN):
//   defined   -> m_last_o marks every BURST_LEN-th accepted beat
//   undefined -> m_last_o is tied low and no beat counter exists
//
// Parameters:
//   WIDTH      data word width in bits
//   BURST_LEN  beats per burst for m_last_o (1..65535)
//
// Ports:
//   clk_i         clock, rising edge
//   resetn_i      asynchronous active-low reset
//   enable_i      1 = issue new FIFO reads
//   fifo_empty_i  upstream FIFO empty flag
//   fifo_rd_o     upstream FIFO read strobe
//   fifo_data_i   upstream read data, valid the cycle after fifo_rd_o
//   m_valid_o     output beat valid
//   m_ready_i     downstream accepts the beat
//   m_data_o      output beat data (head of skid buffer)
//   m_last_o      final beat of a burst
//   words_o       accepted beat count, wraps modulo 2^16
// -----------------------------------------------------------------------------
module fsfifo_drain #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 8
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             enable_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_o,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o,
    output logic [15:0]      words_o
);

    logic             run_q;        // low for the first cycle after reset release
    logic             inflight_q;   // a read was issued last cycle
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic [15:0]      words_q;
    logic [15:0]      words_d;
    logic [WIDTH-1:0] mem_q [3];
    logic [WIDTH-1:0] mem_d [3];
    logic [2:0]       pending_s;
    logic             pop_s;
    logic             cap_s;
    logic [1:0]       wr_idx_s;

    // Entries held plus the word already on its way back from the FIFO.
    assign pending_s = {1'b0, occ_q} + {2'b00, inflight_q};
    assign fifo_rd_o = run_q & enable_i & ~fifo_empty_i & (pending_s < 3'd3);

    assign m_valid_o = (occ_q != 2'd0);
    assign m_data_o  = mem_q[0];
    assign words_o   = words_q;

    assign pop_s    = m_valid_o & m_ready_i;
    assign cap_s    = inflight_q;
    // A pop shifts everything down one slot, so the write lands one lower.
    assign wr_idx_s = occ_q - {1'b0, pop_s};

    // Next-state for occupancy, beat count and buffer contents.
    always_comb begin
        occ_d   = occ_q;
        words_d = words_q;
        if (cap_s && !pop_s) begin
            occ_d = occ_q + 2'd1;
        end else if (pop_s && !cap_s) begin
            occ_d = occ_q - 2'd1;
        end else begin
            occ_d = occ_q;
        end

        if (pop_s) begin
            words_d = words_q + 16'd1;
        end else begin
            words_d = words_q;
        end

        if (pop_s) begin
            mem_d[0] = mem_q[1];
            mem_d[1] = mem_q[2];
        end else begin
            mem_d[0] = mem_q[0];
            mem_d[1] = mem_q[1];
        end
        mem_d[2] = mem_q[2];

        for (int i = 0; i < 3; i++) begin
            if (cap_s && (wr_idx_s == 2'(i))) begin
                mem_d[i] = fifo_data_i;
            end else begin
                mem_d[i] = mem_d[i];
            end
        end
    end

    // Control state: cleared asynchronously, discarding buffered and in-flight data.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            run_q      <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            words_q    <= 16'd0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= fifo_rd_o;
            occ_q      <= occ_d;
            words_q    <= words_d;
        end
    end

    // Skid storage: contents are don't-care after reset, so no reset needed.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 3; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

`ifdef FSFIFO_DRAIN_LAST_EN
    localparam logic [15:0] LAST_CNT = 16'(BURST_LEN - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Beat-in-burst counter advances per accepted beat and wraps after the last.
    always_comb begin
        count_d = count_q;
        if (pop_s) begin
            if (count_q == LAST_CNT) begin
                count_d = 16'd0;
            end else begin
                count_d = count_q + 16'd1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign m_last_o = m_valid_o & (count_q == LAST_CNT);
`else
    assign m_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_fsfifo_drain.sv
module tb_fsfifo_drain;

    localparam int WIDTH     = 32;
    localparam int BURST_LEN = 4;

    logic             clk_i = 1'b0;
    logic             resetn_i;
    logic             enable_i;
    logic             fifo_empty_i;
    logic             fifo_rd_o;
    logic [WIDTH-1:0] fifo_data_i;
    logic             m_valid_o;
    logic             m_ready_i;
    logic [WIDTH-1:0] m_data_o;
    logic             m_last_o;
    logic [15:0]      words_o;

    int checks = 0;
    int errors = 0;

    // Upstream FIFO model contents and expected output order.
    logic [WIDTH-1:0] fifo_mem [$];
    logic [WIDTH-1:0] sb [$];

    // Values sampled in the most recent cycle (just before its rising edge).
    logic             rd_s;
    logic             vld_s;
    logic             acc_s;
    logic             last_s;
    logic [WIDTH-1:0] dat_s;
    int               rd_cnt;
    int               acc_cnt;

    fsfifo_drain #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .enable_i     (enable_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_o    (fifo_rd_o),
        .fifo_data_i  (fifo_data_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .m_last_o     (m_last_o),
        .words_o      (words_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_word(input logic [WIDTH-1:0] w);
        fifo_mem.push_back(w);
        sb.push_back(w);
        fifo_empty_i = 1'b0;
    endtask

    // One clock cycle: sample before the edge, then model the FIFO and scoreboard.
    task automatic cycle();
        logic [WIDTH-1:0] exp_w;
        #1;
        rd_s   = fifo_rd_o;
        vld_s  = m_valid_o;
        acc_s  = m_valid_o && m_ready_i;
        dat_s  = m_data_o;
        last_s = m_last_o;
        @(negedge clk_i);
        if (rd_s) begin
            rd_cnt++;
            if (fifo_mem.size() > 0) fifo_data_i = fifo_mem.pop_front();
        end
        fifo_empty_i = (fifo_mem.size() == 0);
        if (acc_s) begin
            acc_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_order: beat %h delivered, none expected", dat_s);
            end else begin
                exp_w = sb.pop_front();
                if (dat_s !== exp_w) begin
                    errors++;
                    $display("FAIL sb_order: got %h expected %h", dat_s, exp_w);
                end
            end
        end
    endtask

    task automatic do_reset();
        resetn_i     = 1'b0;
        enable_i     = 1'b0;
        m_ready_i    = 1'b0;
        fifo_mem.delete();
        sb.delete();
        fifo_empty_i = 1'b1;
        @(negedge clk_i);
        resetn_i = 1'b1;
        cycle();
        rd_cnt  = 0;
        acc_cnt = 0;
    endtask

    task automatic test_reset();
        resetn_i     = 1'b0;
        enable_i     = 1'b1;
        m_ready_i    = 1'b1;
        fifo_data_i  = '0;
        fifo_empty_i = 1'b1;
        push_word(32'hDEAD_0001);
        #2;
        checks++; if (fifo_rd_o !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b expected 0", fifo_rd_o); end
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", m_valid_o); end
        checks++; if (m_last_o !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", m_last_o); end
        checks++; if (words_o !== 16'd0) begin errors++; $display("FAIL rst_words: got %0d expected 0", words_o); end
        @(negedge clk_i);
        resetn_i = 1'b1;
        rd_cnt  = 0;
        acc_cnt = 0;
        cycle();
        checks++; if (rd_s !== 1'b0) begin errors++; $display("FAIL rst_first_cycle_rd: got %b expected 0", rd_s); end
        cycle();
        checks++; if (rd_s !== 1'b1) begin errors++; $display("FAIL rst_second_cycle_rd: got %b expected 1", rd_s); end
        repeat (4) cycle();
        checks++; if (words_o !== 16'd1) begin errors++; $display("FAIL rst_words_after: got %0d expected 1", words_o); end
    endtask

    task automatic test_latency();
        logic [WIDTH-1:0] lat_w [3];
        lat_w[0] = 32'h11; lat_w[1] = 32'h22; lat_w[2] = 32'h33;
        do_reset();
        push_word(32'h11); push_word(32'h22); push_word(32'h33);
        enable_i  = 1'b1;
        m_ready_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            cycle();
            checks++;
            if (rd_s !== (c <= 2)) begin errors++; $display("FAIL lat_rd c%0d: got %b expected %b", c, rd_s, (c <= 2)); end
            checks++;
            if (vld_s !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL lat_valid c%0d: got %b expected %b", c, vld_s, (c >= 2 && c <= 4)); end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (dat_s !== lat_w[c-2]) begin errors++; $display("FAIL lat_data c%0d: got %h expected %h", c, dat_s, lat_w[c-2]); end
            end
        end
        checks++; if (words_o !== 16'd3) begin errors++; $display("FAIL lat_words: got %0d expected 3", words_o); end
    endtask

    task automatic test_stall_random();
        int guard;
        do_reset();
        for (int i = 0; i < 10; i++) push_word(32'h100 + 32'(i));
        enable_i  = 1'b1;
        m_ready_i = 1'b0;
        repeat (12) begin
            cycle();
            if (vld_s) begin
                checks++;
                if (dat_s !== 32'h100) begin errors++; $display("FAIL stall_hold: got %h expected %h", dat_s, 32'h100); end
            end
        end
        checks++; if (rd_cnt !== 3) begin errors++; $display("FAIL stall_reads: got %0d expected 3", rd_cnt); end
        checks++; if (rd_s !== 1'b0) begin errors++; $display("FAIL stall_rd_low: got %b expected 0", rd_s); end
        guard = 0;
        while (acc_cnt < 10 && guard < 300) begin
            m_ready_i = ($urandom_range(0, 1) == 1);
            cycle();
            guard++;
        end
        checks++; if (acc_cnt !== 10) begin errors++; $display("FAIL random_delivered: got %0d expected 10", acc_cnt); end
        checks++; if (words_o !== 16'd10) begin errors++; $display("FAIL random_words: got %0d expected 10", words_o); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        for (int i = 0; i < 5; i++) push_word(32'h200 + 32'(i));
        enable_i  = 1'b1;
        m_ready_i = 1'b1;
        cycle();
        checks++; if (rd_s !== 1'b1) begin errors++; $display("FAIL endrop_first_rd: got %b expected 1", rd_s); end
        enable_i = 1'b0;
        repeat (6) cycle();
        checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL endrop_reads: got %0d expected 1", rd_cnt); end
        checks++; if (acc_cnt !== 1) begin errors++; $display("FAIL endrop_delivered: got %0d expected 1", acc_cnt); end
        checks++; if (fifo_mem.size() !== 4) begin errors++; $display("FAIL endrop_fifo_left: got %0d expected 4", fifo_mem.size()); end
    endtask

    task automatic test_last();
        int beat;
        int lasts;
        int guard;
        logic exp_last;
        do_reset();
        for (int i = 0; i < 9; i++) push_word(32'h500 + 32'(i));
        enable_i  = 1'b1;
        m_ready_i = 1'b1;
        beat  = 0;
        lasts = 0;
        guard = 0;
        while (acc_cnt < 9 && guard < 30) begin
            cycle();
            guard++;
            if (acc_s) begin
                beat++;
`ifdef FSFIFO_DRAIN_LAST_EN
                exp_last = ((beat % BURST_LEN) == 0);
`else
                exp_last = 1'b0;
`endif
                if (last_s) lasts++;
                checks++;
                if (last_s !== exp_last) begin errors++; $display("FAIL last_beat%0d: got %b expected %b", beat, last_s, exp_last); end
            end else begin
                checks++;
                if (last_s !== 1'b0) begin errors++; $display("FAIL last_idle: got %b expected 0", last_s); end
            end
        end
        checks++; if (acc_cnt !== 9) begin errors++; $display("FAIL last_delivered: got %0d expected 9", acc_cnt); end
`ifdef FSFIFO_DRAIN_LAST_EN
        checks++; if (lasts !== 2) begin errors++; $display("FAIL last_count: got %0d expected 2", lasts); end
`else
        checks++; if (lasts !== 0) begin errors++; $display("FAIL last_count: got %0d expected 0", lasts); end
`endif
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 10; i++) push_word(32'h300 + 32'(i));
        enable_i  = 1'b1;
        m_ready_i = 1'b0;
        repeat (3) cycle();
        checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", m_valid_o); end
        resetn_i = 1'b0;
        fifo_mem.delete();
        sb.delete();
        fifo_empty_i = 1'b1;
        #1;
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", m_valid_o); end
        checks++; if (fifo_rd_o !== 1'b0) begin errors++; $display("FAIL mid_rst_rd: got %b expected 0", fifo_rd_o); end
        @(negedge clk_i);
        resetn_i = 1'b1;
        cycle();
        acc_cnt = 0;
        for (int i = 0; i < 3; i++) push_word(32'h400 + 32'(i));
        m_ready_i = 1'b1;
        repeat (8) cycle();
        checks++; if (acc_cnt !== 3) begin errors++; $display("FAIL mid_new_delivered: got %0d expected 3", acc_cnt); end
        checks++; if (words_o !== 16'd3) begin errors++; $display("FAIL mid_words: got %0d expected 3", words_o); end
    endtask

    task automatic test_back_to_back_wrap();
        int cyc;
        int pushed;
        logic wrap_seen;
        do_reset();
        enable_i  = 1'b1;
        m_ready_i = 1'b1;
        cyc       = 0;
        pushed    = 0;
        wrap_seen = 1'b0;
        while (acc_cnt < 65537 && cyc < 66000) begin
            while (fifo_mem.size() < 4) begin
                push_word(32'hA000_0000 + 32'(pushed));
                pushed++;
            end
            cycle();
            cyc++;
            if (acc_cnt == 65536 && !wrap_seen) begin
                wrap_seen = 1'b1;
                checks++;
                if (words_o !== 16'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", words_o); end
            end
        end
        enable_i  = 1'b0;
        m_ready_i = 1'b0;
        checks++; if (acc_cnt !== 65537) begin errors++; $display("FAIL b2b_delivered: got %0d expected 65537", acc_cnt); end
        checks++; if (cyc !== 65539) begin errors++; $display("FAIL b2b_throughput: got %0d cycles expected 65539", cyc); end
        checks++; if (words_o !== 16'd1) begin errors++; $display("FAIL wrap_words: got %0d expected 1", words_o); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall_random();
        test_enable_drop();
        test_last();
        test_reset_midstream();
        test_back_to_back_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsfifo_drain.md
FSFIFO_DRAIN -- requirements
Module: fsfifo_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-002 SHALL have parameter BURST_LEN, default 8: beats per burst for m_last_o; legal range 1..65535.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port resetn_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable_i, input, 1: 1 = issue new FIFO reads; 0 = stop issuing reads.
REQ-006 SHALL have port fifo_empty_i, input, 1: empty flag from the upstream synchronous FIFO.
REQ-007 SHALL have port fifo_rd_o, output, 1: read strobe to the upstream FIFO.
REQ-008 SHALL have port fifo_data_i, input, WIDTH: FIFO read data, valid the cycle after fifo_rd_o.
REQ-009 SHALL have port m_valid_o, output, 1: output beat valid.
REQ-010 SHALL have port m_ready_i, input, 1: downstream accepts the beat.
REQ-011 SHALL have port m_data_o, output, WIDTH: output beat data.
REQ-012 SHALL have port m_last_o, output, 1: final beat of a burst.
REQ-013 SHALL have port words_o, output, 16: count of accepted beats, wraps modulo 2^16.

Function
REQ-014 SHALL drive fifo_rd_o = enable_i && !fifo_empty_i && (occ + inflight < 3), where occ is the number of skid entries (0..3) and inflight is a 1-bit flag equal to the previous cycle's fifo_rd_o.
REQ-015 SHALL have no combinational path from m_ready_i to fifo_rd_o.
REQ-016 SHALL capture fifo_data_i into a 3-entry in-order skid buffer on the edge ending any cycle in which inflight = 1.
REQ-017 SHALL drive m_valid_o = (occ != 0) and m_data_o = the head entry, both from registers.
REQ-018 SHALL define a beat as accepted when m_valid_o && m_ready_i; each accepted beat pops the head entry.
REQ-019 SHALL allow a capture and a pop in the same cycle, with occ unchanged.
REQ-020 SHALL hold m_data_o stable while m_valid_o && !m_ready_i.
REQ-021 SHALL never overflow the buffer; the occ + inflight <= 3 invariant guarantees this.
REQ-022 SHALL have a latency of 2 cycles: with the FIFO non-empty at cycle N and enable_i = 1, fifo_rd_o = 1 at N and m_valid_o = 1 at N+2.
REQ-023 SHALL sustain 1 beat per cycle while the FIFO is non-empty, enable_i = 1 and m_ready_i = 1.
REQ-024 SHALL still capture an in-flight word after enable_i deasserts, and SHALL continue presenting buffered beats.
REQ-025 SHALL increment words_o by 1 per accepted beat, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL preserve FIFO order exactly, with no beat dropped or duplicated.

Reset
REQ-027 SHALL, on resetn_i low, asynchronously clear occ, inflight, the beat counter and words_o.
REQ-028 SHALL drive fifo_rd_o = 0, m_valid_o = 0, m_last_o = 0 and words_o = 0 during reset.
REQ-029 SHALL discard buffered and in-flight data on reset; the upstream FIFO SHALL be reset in the same event.
REQ-030 SHALL leave skid data contents unspecified after reset.
REQ-031 SHALL release reset synchronously to clk_i; no read is issued in the first cycle after deassertion.

Configuration
REQ-032 SHALL, with FSFIFO_DRAIN_LAST_EN defined, keep a beat counter 0..BURST_LEN-1.
REQ-033 SHALL, with FSFIFO_DRAIN_LAST_EN defined, drive m_last_o = m_valid_o && (count == BURST_LEN-1).
REQ-034 SHALL, with FSFIFO_DRAIN_LAST_EN defined, advance the beat counter per accepted beat and wrap it to 0 after the last beat.
REQ-035 SHALL, with FSFIFO_DRAIN_LAST_EN defined and BURST_LEN = 1, assert m_last_o on every valid beat.
REQ-036 SHALL, without FSFIFO_DRAIN_LAST_EN, tie m_last_o to 0 and omit the beat counter; the port list is identical in both builds.

Verification
REQ-037 SHALL verify: FIFO preloaded 0x11,0x22,0x33, enable_i = 1, m_ready_i = 1 -> m_valid_o at cycle 2, beats 0x11,0x22,0x33 on consecutive cycles, words_o = 3.
REQ-038 SHALL verify: 10 words queued, m_ready_i = 0 -> exactly 3 reads issued, fifo_rd_o = 0 thereafter, m_data_o held at word 0.
REQ-039 SHALL verify: word 3 then m_ready_i random 50% -> all 10 words delivered in order.
REQ-040 SHALL verify: enable_i dropped the cycle after a read -> that word is still delivered and no further reads occur.
REQ-041 SHALL verify: FSFIFO_DRAIN_LAST_EN, BURST_LEN = 4, 9 beats -> m_last_o on beats 4 and 8 only; without the macro, m_last_o = 0 throughout.
REQ-042 SHALL verify: resetn_i pulsed low mid-stream with 2 beats buffered and 1 in flight -> m_valid_o = 0 immediately; after release, new FIFO data only, words_o restarts at 0; 65537 accepted beats -> words_o = 1.
